fxp_div_seq: RTL and testbench
==============================

Name: fxp_div_seq

Overview:
- Parameterised sequential unsigned fixed-point divider. Restoring algorithm, one quotient bit per clock.
- Computes Q = (A << FRAC) / B with WIDTH-bit operands and result; the quotient carries FRAC fractional bits.
- Successor to the fixed 10-bit divider datapath. Adds an integrated controller, start/valid/ready handshake, remainder output, and early overflow abort.
- Sits between operand producers and consumers in the arithmetic unit.

Parameters:
- WIDTH, 10, operand/quotient/remainder width; legal range WIDTH >= 2.
- FRAC, 4, quotient fractional bits; legal range 0 <= FRAC < WIDTH.
- ITER, WIDTH+FRAC (derived localparam), number of iteration steps.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- in_A  input  WIDTH  dividend, unsigned integer; latched on the accepting edge.
- in_B  input  WIDTH  divisor, unsigned integer; latched on the accepting edge.
- busy  output  1  high in CALC and DONE.
- valid  output  1  result valid; high only in DONE.
- ready  input  1  consumer accepts the result when valid & ready.
- q_out  output  WIDTH  quotient, unsigned Q(WIDTH-FRAC).FRAC.
- r_out  output  WIDTH  final partial remainder (< B).
- dvz  output  1  divide-by-zero flag.
- ovf  output  1  quotient does not fit in WIDTH bits.

Behaviour:
- Reset:
  - rst=1 at any time, including mid-operation, immediately forces state IDLE.
  - busy, valid, q_out, r_out, dvz and ovf all go to 0; internal registers and counter clear.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 at an edge latches in_A and in_B, clears the flags and clears the counter.
  - If in_B==0: go to DONE with dvz=1, q_out=0, r_out=0.
  - Otherwise: go to CALC. Dividend register = {in_A, FRAC zeros} (ITER bits); partial remainder = 0 (WIDTH+1 bits).
- CALC, each edge:
  - trial = {rem[WIDTH-1:0], dividend MSB}; shift the dividend left by 1.
  - If trial >= {1'b0,B}: rem = trial - B and quotient bit = 1. Otherwise rem = trial and quotient bit = 0.
  - Shift the quotient bit into the quotient register LSB; counter += 1.
- Overflow abort:
  - Applies when a quotient bit of 1 is produced during any of the first FRAC steps (these are quotient weights >= 2^WIDTH).
  - On that same edge: go to DONE with ovf=1, q_out=0, r_out=0.
  - No further iterations run.
- Normal end: on the edge completing step ITER, go to DONE with q_out = low WIDTH bits of the quotient and r_out = rem[WIDTH-1:0].
- DONE:
  - valid=1; q_out, r_out, dvz and ovf are held stable.
  - valid & ready at an edge goes to IDLE and drops valid on that edge.
  - The next request is accepted no earlier than the following edge (one idle cycle minimum between results).
- Latency, with edge 0 = the accepting edge:
  - valid rises after edge ITER for a normal result.
  - valid rises after edge 0 for dvz.
  - valid rises after edge k for an abort at step k (1 <= k <= FRAC).
- Flag rules:
  - dvz and ovf are mutually exclusive.
  - Flags are valid only while valid=1; they are cleared on acceptance of the next request.
- Input isolation:
  - start while busy=1 is ignored, with no queueing.
  - in_A and in_B changes after the accepting edge have no effect.
- FRAC=0: the abort check never fires, so ovf is always 0 and the block reduces to a plain integer divider.
- Width rules:
  - Counter width = $clog2(ITER+1).
  - Subtraction is WIDTH+1 bits wide, so no carry is lost.
  - All arithmetic is unsigned.

Test Plan (WIDTH=10, FRAC=4, ITER=14):
- Normal result: in_A=10, in_B=4, start pulse, ready=1 -> valid after 14 CALC edges; q_out=40 (2.5), r_out=0, dvz=0, ovf=0; busy low one edge after acceptance.
- Remainder: in_A=7, in_B=3 -> q_out=37, r_out=1, flags 0.
- Divide by zero: in_B=0, in_A=123 -> valid one edge after start; dvz=1, ovf=0, q_out=0, r_out=0.
- Overflow abort:
  - in_A=1023, in_B=1 -> abort at step 1; valid after edge 1, ovf=1, q_out=0.
  - in_A=64, in_B=1 -> abort at step 4; valid after edge 4, ovf=1.
  - in_A=63, in_B=1 -> full 14 steps, q_out=1008, ovf=0 (boundary).
- Backpressure and isolation:
  - Hold ready=0 for 5 cycles in DONE -> valid and outputs stable.
  - Pulse start and change in_A mid-CALC -> ignored, result unchanged.
  - ready=1 -> IDLE; a back-to-back start on the next edge is accepted.
- Reset mid-operation: assert rst asynchronously at step 6 of in_A=10, in_B=4 -> all outputs 0 immediately, no valid. After release, a new start in_A=9, in_B=2 -> q_out=72, r_out=0.

Source files
------------

// File: rtl/fxp_div_seq.sv
// Sequential unsigned fixed-point divider: Q = (A << FRAC) / B, restoring, one bit per clock.
// Start/valid/ready handshake with divide-by-zero and early overflow abort.
module fxp_div_seq #(
  parameter int WIDTH = 10,
  parameter int FRAC  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in_A,
  input  logic [WIDTH-1:0] in_B,
  output logic             busy,
  output logic             valid,
  input  logic             ready,
  output logic [WIDTH-1:0] q_out,
  output logic [WIDTH-1:0] r_out,
  output logic             dvz,
  output logic             ovf
);

  localparam int ITER = WIDTH + FRAC;
  localparam int CW   = $clog2(ITER + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [ITER-1:0]  div_q, div_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] q_out_q, q_out_d;
  logic [WIDTH-1:0] r_out_q, r_out_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dvz_q, dvz_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   trial, diff;
  logic             qbit, abort, last;
  logic [1:0]       unused_bits;

  assign trial = {rem_q[WIDTH-1:0], div_q[ITER-1]};
  assign diff  = trial - {1'b0, b_q};
  assign qbit  = (trial >= {1'b0, b_q});
  // A 1 in the first FRAC steps has weight >= 2^WIDTH, so the result cannot fit.
  assign abort = qbit && (cnt_q < CW'(FRAC));
  assign last  = (cnt_q == CW'(ITER - 1));
  assign unused_bits = {rem_q[WIDTH], quo_q[WIDTH-1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = (in_B == '0) ? DONE : CALC;
      CALC: if (abort || last) state_d = DONE;
      DONE: if (ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    div_d   = div_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    q_out_d = q_out_q;
    r_out_d = r_out_q;
    dvz_d   = dvz_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          b_d     = in_B;
          div_d   = ITER'(in_A) << FRAC;
          rem_d   = '0;
          quo_d   = '0;
          cnt_d   = '0;
          q_out_d = '0;
          r_out_d = '0;
          dvz_d   = (in_B == '0);
          ovf_d   = 1'b0;
        end
      end
      CALC: begin
        div_d = div_q << 1;
        rem_d = qbit ? diff : trial;
        quo_d = {quo_q[WIDTH-2:0], qbit};
        cnt_d = cnt_q + CW'(1);
        if (abort) begin
          ovf_d   = 1'b1;
          q_out_d = '0;
          r_out_d = '0;
        end else if (last) begin
          q_out_d = {quo_q[WIDTH-2:0], qbit};
          r_out_d = rem_d[WIDTH-1:0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      q_out_q <= '0;
      r_out_q <= '0;
      dvz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      div_q   <= div_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      q_out_q <= q_out_d;
      r_out_q <= r_out_d;
      dvz_q   <= dvz_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    busy  = (state_q != IDLE);
    valid = (state_q == DONE);
    q_out = q_out_q;
    r_out = r_out_q;
    dvz   = dvz_q;
    ovf   = ovf_q;
  end

endmodule

// File: tb/tb_fxp_div_seq.sv
// Bench for fxp_div_seq: directed plan cases plus random operands against an arithmetic model.
module tb_fxp_div_seq;
  localparam int WIDTH = 10;
  localparam int FRAC  = 4;
  localparam int ITER  = WIDTH + FRAC;

  logic             clk = 1'b0;
  logic             rst, start, ready;
  logic [WIDTH-1:0] in_A, in_B;
  logic             busy, valid, dvz, ovf;
  logic [WIDTH-1:0] q_out, r_out;

  int checks = 0;
  int errors = 0;

  fxp_div_seq #(.WIDTH(WIDTH), .FRAC(FRAC)) dut (
    .clk(clk), .rst(rst), .start(start), .in_A(in_A), .in_B(in_B),
    .busy(busy), .valid(valid), .ready(ready), .q_out(q_out), .r_out(r_out),
    .dvz(dvz), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Quotient bit of weight 2^p is produced at step ITER-p.
  function automatic void model(input int a, input int b, output int q, output int r,
                                output int d, output int o, output int lat);
    logic [63:0] num, qf;
    int p;
    num = 64'(a) << FRAC;
    q = 0; r = 0; d = 0; o = 0; lat = ITER;
    if (b == 0) begin
      d = 1; lat = 0;
    end else begin
      qf = num / 64'(b);
      if (qf >= (64'd1 << WIDTH)) begin
        o = 1; p = 0;
        for (int i = 0; i < ITER; i++) if (qf[i]) p = i;
        lat = ITER - p;
      end else begin
        q = int'(qf);
        r = int'(num % 64'(b));
      end
    end
  endfunction

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!valid) chk("valid_timeout", 32'(valid), 32'd1);
  endtask

  task automatic run(input string tag, input int a, input int b, input int hold,
                     input int eq, input int er, input int ed, input int eo, input int elat);
    int lat;
    logic [WIDTH-1:0] q0, r0;
    @(negedge clk);
    in_A = WIDTH'(a); in_B = WIDTH'(b); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_A = WIDTH'($urandom); in_B = WIDTH'($urandom);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    wait_valid(lat);
    chk({tag, "_lat"}, 32'(lat), 32'(elat));
    chk({tag, "_q"}, 32'(q_out), 32'(eq));
    chk({tag, "_r"}, 32'(r_out), 32'(er));
    chk({tag, "_dvz"}, 32'(dvz), 32'(ed));
    chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
    q0 = q_out; r0 = r_out;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, 32'(valid), 32'd1);
      chk({tag, "_hold_q"}, 32'(q_out), 32'(q0));
      chk({tag, "_hold_r"}, 32'(r_out), 32'(r0));
    end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    chk({tag, "_drop_valid"}, 32'(valid), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int q, r, d, o, lat, a, b, sel;
    rst = 1'b1; start = 1'b0; ready = 1'b0; in_A = '0; in_B = '0;
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_q", 32'(q_out), 32'd0);
    chk("rst_flags", 32'({dvz, ovf}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run("norm", 10, 4, 5, 40, 0, 0, 0, 14);
    run("rem", 7, 3, 0, 37, 1, 0, 0, 14);
    run("dvz", 123, 0, 0, 0, 0, 1, 0, 0);
    run("ovf1", 1023, 1, 0, 0, 0, 0, 1, 1);
    run("ovf4", 64, 1, 0, 0, 0, 0, 1, 4);
    run("bound", 63, 1, 0, 1008, 0, 0, 0, 14);

    // start pulse and operand change mid-CALC must be ignored
    @(negedge clk);
    in_A = 10; in_B = 4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; in_A = 500; in_B = 7;
    @(negedge clk);
    start = 1'b0;
    wait_valid(lat);
    chk("iso_q", 32'(q_out), 32'd40);
    chk("iso_r", 32'(r_out), 32'd0);

    // back-to-back: start held with ready; accepted on the edge after returning to IDLE
    ready = 1'b1; start = 1'b1; in_A = 7; in_B = 3;
    @(negedge clk);
    ready = 1'b0;
    chk("b2b_valid_drop", 32'(valid), 32'd0);
    chk("b2b_idle", 32'(busy), 32'd0);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_accept", 32'(busy), 32'd1);
    wait_valid(lat);
    chk("b2b_lat", 32'(lat), 32'd14);
    chk("b2b_q", 32'(q_out), 32'd37);
    chk("b2b_r", 32'(r_out), 32'd1);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;

    // asynchronous reset during step 6
    @(negedge clk);
    in_A = 10; in_B = 4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_valid", 32'(valid), 32'd0);
    chk("arst_q", 32'(q_out), 32'd0);
    chk("arst_r", 32'(r_out), 32'd0);
    chk("arst_flags", 32'({dvz, ovf}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("arst_no_valid", 32'(valid), 32'd0);
    end
    run("post_rst", 9, 2, 0, 72, 0, 0, 0, 14);

    for (int n = 0; n < 40; n++) begin
      a = int'($urandom_range(0, 1023));
      sel = int'($urandom_range(0, 4));
      if (sel == 0)      b = 0;
      else if (sel == 1) b = int'($urandom_range(1, 3));
      else if (sel == 2) b = int'($urandom_range(1, 63));
      else               b = int'($urandom_range(1, 1023));
      model(a, b, q, r, d, o, lat);
      run("rand", a, b, n % 3, q, r, d, o, lat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed %0d expected %0d", checks, 0);
    $fatal(1, "global timeout");
  end
endmodule
